coffee_dispenser: RTL and testbench

//  Dispense-side responder to the vend controller. Accepts the level-held

---
 rtl/coffee_dispenser_pkg.sv | 45 ++++
 rtl/coffee_dispenser_token_payout.sv | 89 ++++++++
 rtl/coffee_dispenser.sv | 153 +++++++++++++++
 tb/tb_coffee_dispenser.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coffee_dispenser_pkg.sv
// Shared codes for the coffee dispenser: drink selects, flavour valve one-hots,
// FSM state encodings and small decode helpers.
package coffee_dispenser_pkg;

  localparam logic [2:0] SelPlain = 3'd1;
  localparam logic [2:0] SelHazel = 3'd2;
  localparam logic [2:0] SelCoco  = 3'd3;

  localparam logic [1:0] FlavNone  = 2'b00;
  localparam logic [1:0] FlavHazel = 2'b01;
  localparam logic [1:0] FlavCoco  = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StCup,
    StPour,
    StFlav,
    StDone,
    StRelease
  } brew_state_e;

  typedef enum logic [1:0] {
    PayIdle,
    PayHigh,
    PayGap
  } pay_state_e;

  function automatic logic sel_valid(input logic [2:0] sel);
    return (sel == SelPlain) || (sel == SelHazel) || (sel == SelCoco);
  endfunction

  function automatic logic [1:0] flav_code(input logic [2:0] sel);
    case (sel)
      SelHazel: return FlavHazel;
      SelCoco:  return FlavCoco;
      default:  return FlavNone;
    endcase
  endfunction

  // Bits needed to hold max_val - 1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/coffee_dispenser_token_payout.sv
// Change payout: saturating 8-bit token backlog paid out as fixed-width
// token_out pulses separated by a fixed low gap.
module coffee_dispenser_token_payout
  import coffee_dispenser_pkg::*;
#(
  parameter int unsigned TokenHigh = 2,
  parameter int unsigned TokenGap  = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       vend_busy_i,
  input  logic [7:0] change_tokens_i,
  output logic       token_out_o,
  output logic       change_busy_o
);

  localparam int unsigned MaxPhase = (TokenHigh > TokenGap) ? TokenHigh : TokenGap;
  localparam int unsigned CntW     = cnt_width(MaxPhase);

  pay_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      rem_q, rem_d;
  logic            token_q, token_d;
  logic            busy_q, busy_d;
  logic            dec;
  logic [8:0]      sum;

  always_comb begin
    // Decrement and new change merge into one update so no token is lost.
    dec   = (state_q == PayHigh) && (cnt_q == '0);
    sum   = {1'b0, rem_q} - {8'd0, dec} + (vend_busy_i ? {1'b0, change_tokens_i} : 9'd0);
    rem_d = sum[8] ? 8'hFF : sum[7:0];

    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      PayIdle: begin
        if (rem_d != '0) begin
          state_d = PayHigh;
          cnt_d   = CntW'(TokenHigh - 1);
        end
      end
      PayHigh: begin
        if (cnt_q == '0) begin
          state_d = PayGap;
          cnt_d   = CntW'(TokenGap - 1);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      PayGap: begin
        if (cnt_q == '0) begin
          if (rem_d != '0) begin
            state_d = PayHigh;
            cnt_d   = CntW'(TokenHigh - 1);
          end else begin
            state_d = PayIdle;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = PayIdle;
    endcase

    token_d = (state_d == PayHigh);
    busy_d  = (rem_d != '0) || (state_d != PayIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PayIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      token_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      token_q <= token_d;
      busy_q  <= busy_d;
    end
  end

  assign token_out_o   = token_q;
  assign change_busy_o = busy_q;

endmodule

// File: rtl/coffee_dispenser.sv
// Dispense-side responder: brews cup/water/flavour sequences on request and
// pays out change tokens through an independent payout engine.
module coffee_dispenser
  import coffee_dispenser_pkg::*;
#(
  parameter int unsigned CupCycles     = 4,
  parameter int unsigned PourCycles    = 16,
  parameter int unsigned FlavourCycles = 8,
  parameter int unsigned TokenHigh     = 2,
  parameter int unsigned TokenGap      = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       dispense_i,
  input  logic [2:0] coffee_select_i,
  input  logic       vend_busy_i,
  input  logic [7:0] change_tokens_i,
  output logic       dispense_done_o,
  output logic       cup_drop_o,
  output logic       water_valve_o,
  output logic [1:0] flavour_valve_o,
  output logic       fault_o,
  output logic       token_out_o,
  output logic       change_busy_o
);

  localparam int unsigned MaxCP     = (CupCycles > PourCycles) ? CupCycles : PourCycles;
  localparam int unsigned MaxCycles = (MaxCP > FlavourCycles) ? MaxCP : FlavourCycles;
  localparam int unsigned CntW      = cnt_width(MaxCycles);

  brew_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      sel_q, sel_d;
  logic            cup_q, cup_d;
  logic            water_q, water_d;
  logic [1:0]      flav_q, flav_d;
  logic            done_q, done_d;
  logic            fault_q, fault_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    cup_d   = 1'b0;
    water_d = 1'b0;
    flav_d  = FlavNone;
    done_d  = 1'b0;
    fault_d = fault_q;
    unique case (state_q)
      StIdle: begin
        if (dispense_i) begin
          if (sel_valid(coffee_select_i)) begin
            state_d = StCup;
            sel_d   = coffee_select_i;
            cnt_d   = CntW'(CupCycles - 1);
            cup_d   = 1'b1;
          end else begin
            fault_d = 1'b1;
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      StCup: begin
        if (!dispense_i) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StPour;
          cnt_d   = CntW'(PourCycles - 1);
          water_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
          cup_d = 1'b1;
        end
      end
      StPour: begin
        if (!dispense_i) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          if (sel_q == SelPlain) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StFlav;
            cnt_d   = CntW'(FlavourCycles - 1);
            flav_d  = flav_code(sel_q);
          end
        end else begin
          cnt_d   = cnt_q - CntW'(1);
          water_d = 1'b1;
        end
      end
      StFlav: begin
        if (!dispense_i) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q - CntW'(1);
          flav_d = flav_code(sel_q);
        end
      end
      StDone: state_d = StRelease;
      // Hold here until the request drops so a stale level cannot retrigger.
      StRelease: begin
        if (!dispense_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_q   <= '0;
      cup_q   <= 1'b0;
      water_q <= 1'b0;
      flav_q  <= FlavNone;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      cup_q   <= cup_d;
      water_q <= water_d;
      flav_q  <= flav_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign dispense_done_o = done_q;
  assign cup_drop_o      = cup_q;
  assign water_valve_o   = water_q;
  assign flavour_valve_o = flav_q;
  assign fault_o         = fault_q;

  coffee_dispenser_token_payout #(
    .TokenHigh(TokenHigh),
    .TokenGap (TokenGap)
  ) u_token_payout (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .vend_busy_i    (vend_busy_i),
    .change_tokens_i(change_tokens_i),
    .token_out_o    (token_out_o),
    .change_busy_o  (change_busy_o)
  );

endmodule

// File: tb/tb_coffee_dispenser.sv
// Self-checking bench for coffee_dispenser: timeline model of the brew schedule
// and token payout, compared every cycle, plus literal per-scenario checks.
module tb_coffee_dispenser;

  localparam int Cup  = 4;
  localparam int Pour = 16;
  localparam int Flav = 8;
  localparam int Th   = 2;
  localparam int Tg   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dispense = 1'b0;
  logic [2:0] sel = 3'd0;
  logic       vend_busy = 1'b0;
  logic [7:0] tokens = 8'd0;
  logic       done, cup, water, fault, tok, busy;
  logic [1:0] flav;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  coffee_dispenser dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .dispense_i     (dispense),
    .coffee_select_i(sel),
    .vend_busy_i    (vend_busy),
    .change_tokens_i(tokens),
    .dispense_done_o(done),
    .cup_drop_o     (cup),
    .water_valve_o  (water),
    .flavour_valve_o(flav),
    .fault_o        (fault),
    .token_out_o    (tok),
    .change_busy_o  (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Brew model: mode 0 idle, 1 brewing (t = cycle number since acceptance), 2 awaiting release.
  int         m_mode = 0, m_t = 0, m_done_at = 0;
  logic       m_valid = 1'b0, m_fault = 1'b0;
  logic [1:0] m_flav = 2'b00;
  // Payout model: owed tokens and position within the current 4-cycle pulse period.
  int         m_rem = 0, m_pos = 0;

  always @(posedge clk or negedge rst_n) begin
    int add, dec;
    if (!rst_n) begin
      m_mode = 0; m_t = 0; m_done_at = 0; m_valid = 1'b0; m_fault = 1'b0;
      m_flav = 2'b00; m_rem = 0; m_pos = 0;
    end else begin
      case (m_mode)
        0: if (dispense) begin
          m_mode = 1;
          m_t    = 1;
          if (sel >= 3'd1 && sel <= 3'd3) begin
            m_valid   = 1'b1;
            m_done_at = (sel == 3'd1) ? Cup + Pour + 1 : Cup + Pour + Flav + 1;
            m_flav    = (sel == 3'd2) ? 2'b01 : (sel == 3'd3) ? 2'b10 : 2'b00;
          end else begin
            m_valid   = 1'b0;
            m_fault   = 1'b1;
            m_done_at = 1;
          end
        end
        1: begin
          if (m_t == m_done_at) m_mode = 2;
          else if (!dispense) m_mode = 0;
          else m_t++;
        end
        default: if (!dispense) m_mode = 0;
      endcase

      add = vend_busy ? int'(tokens) : 0;
      if (m_pos == 0) begin
        m_rem = (m_rem + add > 255) ? 255 : m_rem + add;
        m_pos = (m_rem != 0) ? 1 : 0;
      end else begin
        dec   = (m_pos == Th) ? 1 : 0;
        m_rem = (m_rem - dec + add > 255) ? 255 : m_rem - dec + add;
        if (m_pos < Th + Tg) m_pos++;
        else m_pos = (m_rem != 0) ? 1 : 0;
      end
    end
  end

  // Scenario counters; rel is the cycle number since the armed request edge.
  logic       arm = 1'b0;
  logic       tok_prev = 1'b0;
  int         rel = 0, done_at = 0;
  int         cup_cnt = 0, water_cnt = 0, flav_cnt = 0, done_cnt = 0;
  int         pulses = 0, tok_hi = 0, busy_cnt = 0;
  logic [1:0] last_flav = 2'b00;

  always @(posedge clk) begin
    logic       e_cup, e_water, e_done, e_tok, e_busy, in_brew;
    logic [1:0] e_flav;
    if (arm) begin
      rel = 1;
      arm = 1'b0;
    end else begin
      rel++;
    end
    #2;
    if (rst_n) begin
      in_brew = (m_mode == 1) && m_valid;
      e_cup   = in_brew && m_t >= 1 && m_t <= Cup;
      e_water = in_brew && m_t > Cup && m_t <= Cup + Pour;
      e_flav  = (in_brew && m_t > Cup + Pour && m_t <= Cup + Pour + Flav) ? m_flav : 2'b00;
      e_done  = (m_mode == 1) && (m_t == m_done_at);
      e_tok   = (m_pos >= 1) && (m_pos <= Th);
      e_busy  = (m_rem != 0) || (m_pos != 0);
      chk("cup_drop", int'(cup), int'(e_cup));
      chk("water_valve", int'(water), int'(e_water));
      chk("flavour_valve", int'(flav), int'(e_flav));
      chk("dispense_done", int'(done), int'(e_done));
      chk("fault", int'(fault), int'(m_fault));
      chk("token_out", int'(tok), int'(e_tok));
      chk("change_busy", int'(busy), int'(e_busy));

      if (cup) cup_cnt++;
      if (water) water_cnt++;
      if (flav != 2'b00) begin
        flav_cnt++;
        last_flav = flav;
      end
      if (done) begin
        done_cnt++;
        done_at = rel;
      end
      if (tok && !tok_prev) pulses++;
      if (tok) tok_hi++;
      if (busy) busy_cnt++;
      tok_prev = tok;
    end
  end

  task automatic clr();
    cup_cnt = 0; water_cnt = 0; flav_cnt = 0; done_cnt = 0; done_at = 0;
    pulses = 0; tok_hi = 0; busy_cnt = 0; last_flav = 2'b00; rel = 0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (n == 6) sel = 3'd0;  // mid-brew select change must be ignored
    end
    chk("done_within_budget", int'(done_cnt != 0), 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("payout_within_budget", int'(busy), 0);
  endtask

  task automatic wait_rel(input int target);
    int n = 0;
    while (rel != target && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("reach_cycle", rel, target);
  endtask

  task automatic brew(input logic [2:0] s);
    @(negedge clk);
    clr();
    dispense = 1'b1;
    sel      = s;
    arm      = 1'b1;
    wait_done(40);
    dispense = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cup", int'(cup), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;

    brew(3'd1);
    chk("plain_cup_cycles", cup_cnt, 4);
    chk("plain_water_cycles", water_cnt, 16);
    chk("plain_flav_cycles", flav_cnt, 0);
    chk("plain_done_count", done_cnt, 1);
    chk("plain_done_cycle", done_at, 21);

    brew(3'd3);
    chk("coco_flav_cycles", flav_cnt, 8);
    chk("coco_flav_code", int'(last_flav), 2);
    chk("coco_done_cycle", done_at, 29);

    brew(3'd2);
    chk("hazel_flav_code", int'(last_flav), 1);
    chk("hazel_done_cycle", done_at, 29);

    brew(3'd0);
    chk("inval_fault", int'(fault), 1);
    chk("inval_done_cycle", done_at, 1);
    chk("inval_actuators", cup_cnt + water_cnt + flav_cnt, 0);
    brew(3'd1);
    chk("fault_sticky", int'(fault), 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("fault_cleared", int'(fault), 0);

    // Three tokens: 2 high / 2 low each, busy for 12 cycles.
    @(negedge clk);
    clr();
    vend_busy = 1'b1;
    tokens    = 8'd3;
    @(negedge clk);
    vend_busy = 1'b0;
    tokens    = 8'd0;
    repeat (20) @(negedge clk);
    chk("pay3_pulses", pulses, 3);
    chk("pay3_high_cycles", tok_hi, 6);
    chk("pay3_busy_cycles", busy_cnt, 12);

    // Remaining 2 plus 254 saturates at 255.
    @(negedge clk);
    clr();
    vend_busy = 1'b1;
    tokens    = 8'd2;
    @(negedge clk);
    tokens    = 8'd254;
    @(negedge clk);
    vend_busy = 1'b0;
    tokens    = 8'd0;
    wait_idle(1200);
    chk("sat_pulses", pulses, 255);
    chk("sat_high_cycles", tok_hi, 510);

    // Strobe on the decrement edge, concurrent with a coconut brew.
    @(negedge clk);
    clr();
    dispense  = 1'b1;
    sel       = 3'd3;
    arm       = 1'b1;
    vend_busy = 1'b1;
    tokens    = 8'd3;
    @(negedge clk);
    vend_busy = 1'b0;
    @(negedge clk);
    vend_busy = 1'b1;
    tokens    = 8'd2;
    @(negedge clk);
    vend_busy = 1'b0;
    tokens    = 8'd0;
    wait_done(60);
    dispense = 1'b0;
    wait_idle(100);
    chk("coincide_pulses", pulses, 5);
    chk("concurrent_done_cycle", done_at, 29);

    // Asynchronous reset mid-pour with change pending.
    @(negedge clk);
    clr();
    dispense  = 1'b1;
    sel       = 3'd1;
    arm       = 1'b1;
    vend_busy = 1'b1;
    tokens    = 8'd5;
    @(negedge clk);
    vend_busy = 1'b0;
    tokens    = 8'd0;
    wait_rel(10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cup", int'(cup), 0);
    chk("arst_water", int'(water), 0);
    chk("arst_flav", int'(flav), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_fault", int'(fault), 0);
    chk("arst_token", int'(tok), 0);
    chk("arst_busy", int'(busy), 0);
    dispense = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_change_discarded", int'(busy), 0);

    // Request dropped mid-pour: valves close next cycle, no done.
    @(negedge clk);
    clr();
    dispense = 1'b1;
    sel      = 3'd1;
    arm      = 1'b1;
    wait_rel(10);
    dispense = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_water_cycles", water_cnt, 6);
    chk("abort_cup_cycles", cup_cnt, 4);
    chk("abort_no_done", done_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
